// File: rtl/picorv32_mem_responder_pkg.sv
// Shared types and helpers for the PicoRV32 native-bus memory responder.
package picorv32_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int MEM_DEPTH_WORDS = 256;
  localparam int MEM_IDX_BITS    = $clog2(MEM_DEPTH_WORDS);

  // Requests above the configured maximum are silently limited, never flagged.
  function automatic int clamp_wait(input int req, input int max_wait);
    return (req > max_wait) ? max_wait : req;
  endfunction

endpackage

// File: rtl/picorv32_mem_responder_if.sv
// PicoRV32 native memory bus: core drives the request, responder the reply.
interface picorv32_mem_responder_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/picorv32_mem_responder_ram.sv
// Word-wide backing store: combinational read, byte-masked synchronous write.
// Contents start at zero and are deliberately untouched by reset.
module picorv32_mem_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_BITS    = 8
) (
  input  logic                clock,
  input  logic                we,
  input  logic [IDX_BITS-1:0] idx,
  input  logic [31:0]         wdata,
  input  logic [3:0]          wstrb,
  output logic [31:0]         rdata
);

  logic [31:0] mem [DEPTH_WORDS] = '{default: 32'h0};

  assign rdata = mem[idx];

  // Update only the enabled byte lanes of the addressed word.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/picorv32_mem_responder.sv
// Memory responder for the PicoRV32 native bus with bounded wait states and
// a sticky checker for core-side handshake violations.
module picorv32_mem_responder
  import picorv32_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = MEM_DEPTH_WORDS,
  parameter int MAX_WAIT    = 4,
  parameter int WAIT_BITS   = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  picorv32_mem_responder_if.slave bus,
  input  logic [WAIT_BITS-1:0] wait_cycles,
  output logic                 busy,
  output logic                 protocol_error,
  output logic                 misaligned
);

  localparam int IDX_BITS = $clog2(DEPTH_WORDS);

  state_t               state;
  logic [WAIT_BITS-1:0] cnt;
  logic [31:0]          cap_addr;
  logic [31:0]          cap_wdata;
  logic [3:0]           cap_wstrb;
  logic                 cap_instr;
  logic [31:0]          ram_rdata;
  logic                 ram_we;
  logic                 viol;

  // The write lands on the edge that closes RESP; a coincident reset cancels it.
  assign ram_we = (state == RESP) && (cap_wstrb != 4'h0) && !reset;

  // The core must hold a stable request from acceptance until it sees ready.
  assign viol = !bus.mem_valid
             || (bus.mem_addr  != cap_addr)
             || (bus.mem_wdata != cap_wdata)
             || (bus.mem_wstrb != cap_wstrb)
             || (bus.mem_instr != cap_instr);

  picorv32_mem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_BITS   (IDX_BITS)
  ) u_ram (
    .clock(clock),
    .we   (ram_we),
    .idx  (cap_addr[IDX_BITS+1:2]),
    .wdata(cap_wdata),
    .wstrb(cap_wstrb),
    .rdata(ram_rdata)
  );

  // Request/response sequencing with registered ready, data and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      cap_addr       <= '0;
      cap_wdata      <= '0;
      cap_wstrb      <= '0;
      cap_instr      <= 1'b0;
      bus.mem_ready  <= 1'b0;
      bus.mem_rdata  <= '0;
      busy           <= 1'b0;
      protocol_error <= 1'b0;
      misaligned     <= 1'b0;
    end else begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
      case (state)
        IDLE: begin
          if (bus.mem_valid) begin
            cap_addr  <= bus.mem_addr;
            cap_wdata <= bus.mem_wdata;
            cap_wstrb <= bus.mem_wstrb;
            cap_instr <= bus.mem_instr;
            cnt       <= WAIT_BITS'(clamp_wait(int'(wait_cycles), MAX_WAIT));
            busy      <= 1'b1;
            state     <= WAIT;
            if (bus.mem_addr[1:0] != 2'b00) misaligned <= 1'b1;
          end
        end
        WAIT: begin
          if (viol) protocol_error <= 1'b1;
          if (cnt == '0) begin
            // Store is stable until RESP ends, so this is also the pre-write word.
            bus.mem_ready <= 1'b1;
            bus.mem_rdata <= ram_rdata;
            state         <= RESP;
          end else begin
            cnt <= cnt - WAIT_BITS'(1);
          end
        end
        RESP: begin
          if (viol) protocol_error <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Randomised bench for the memory responder against a word-array reference.
module tb_picorv32_mem_responder;

  localparam int DEPTH = 256;
  localparam int MAXW  = 4;
  localparam int WB    = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [WB-1:0] wait_cycles;
  logic          busy;
  logic          protocol_error;
  logic          misaligned;

  picorv32_mem_responder_if bus ();

  picorv32_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .MAX_WAIT   (MAXW),
    .WAIT_BITS  (WB)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .wait_cycles   (wait_cycles),
    .busy          (busy),
    .protocol_error(protocol_error),
    .misaligned    (misaligned)
  );

  always #5 clock = ~clock;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_mem [DEPTH];
  logic        exp_mis;
  logic        exp_perr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One transaction starting now (just after a rising edge); checks every cycle
  // up to and including the ready cycle, then updates the reference store.
  // drop_k > 0 releases mem_valid at the start of that cycle offset.
  task automatic txn(input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input logic instr,
                     input int wt, input int drop_k);
    int          w;
    int          idx;
    logic [31:0] old;
    logic        mis0;
    logic        perr0;
    w     = (wt > MAXW) ? MAXW : wt;
    idx   = int'(addr / 4) % DEPTH;
    old   = model_mem[idx];
    mis0  = exp_mis;
    perr0 = exp_perr;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
    bus.mem_instr = instr;
    wait_cycles   = WB'(wt);
    for (int k = 0; k <= w + 2; k++) begin
      if (k == drop_k) bus.mem_valid = 1'b0;
      if (k == 1) wait_cycles = WB'($urandom);
      @(negedge clock);
      chk("ready", {31'b0, bus.mem_ready}, {31'b0, k == w + 2});
      chk("busy", {31'b0, busy}, {31'b0, k >= 1});
      chk("rdata", bus.mem_rdata, (k == w + 2) ? old : 32'h0);
      chk("misaligned", {31'b0, misaligned},
          {31'b0, mis0 || (k >= 1 && addr[1:0] != 2'b00)});
      chk("protocol_error", {31'b0, protocol_error},
          {31'b0, perr0 || (drop_k > 0 && k > drop_k)});
      @(posedge clock); #1;
    end
    for (int b = 0; b < 4; b++)
      if (wstrb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    if (addr[1:0] != 2'b00) exp_mis = 1'b1;
    if (drop_k > 0) exp_perr = 1'b1;
  endtask

  task automatic idle(input int n);
    bus.mem_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      wait_cycles = WB'($urandom);
      @(negedge clock);
      chk("idle_ready", {31'b0, bus.mem_ready}, 32'h0);
      chk("idle_busy", {31'b0, busy}, 32'h0);
      chk("idle_rdata", bus.mem_rdata, 32'h0);
      chk("idle_misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
      chk("idle_protocol_error", {31'b0, protocol_error}, {31'b0, exp_perr});
      @(posedge clock); #1;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    reset         = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_instr = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    wait_cycles   = '0;
    exp_mis       = 1'b0;
    exp_perr      = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", {31'b0, bus.mem_ready}, 32'h0);
    chk("rst_rdata", bus.mem_rdata, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_protocol_error", {31'b0, protocol_error}, 32'h0);
    chk("rst_misaligned", {31'b0, misaligned}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(1);

    // Word write then read, zero wait.
    txn(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 0, -1);
    idle(1);
    txn(32'h10, 32'h0, 4'h0, 1'b1, 0, -1);
    idle(1);

    // Byte-lane merge, issued back to back.
    txn(32'h40, 32'h11223344, 4'hF, 1'b0, 1, -1);
    txn(32'h40, 32'h000000AA, 4'h1, 1'b0, 0, -1);
    txn(32'h40, 32'h0, 4'h0, 1'b0, 2, -1);
    idle(2);

    // Clamped wait: 7 behaves as MAX_WAIT.
    txn(32'h80, 32'h0, 4'h0, 1'b0, 7, -1);
    idle(1);

    // Address wrap, then a misaligned request whose flag must persist.
    txn(32'h00000400, 32'h00000055, 4'hF, 1'b0, 2, -1);
    idle(1);
    txn(32'h00000000, 32'h0, 4'h0, 1'b0, 0, -1);
    idle(1);
    txn(32'h00000002, 32'h0, 4'h0, 1'b0, 1, -1);
    idle(3);

    // Valid dropped one cycle after acceptance of a wait-3 read.
    txn(32'h10, 32'h0, 4'h0, 1'b0, 3, 1);
    idle(3);

    // Reset two cycles into a wait-3 write: abandoned, nothing stored.
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h20;
    bus.mem_wdata = 32'hFFFFFFFF;
    bus.mem_wstrb = 4'hF;
    bus.mem_instr = 1'b0;
    wait_cycles   = 3'd3;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) reset = 1'b1;
      if (k == 3) begin
        reset         = 1'b0;
        bus.mem_valid = 1'b0;
      end
      @(negedge clock);
      chk("rstmid_ready", {31'b0, bus.mem_ready}, 32'h0);
      if (k >= 3) begin
        chk("rstmid_busy", {31'b0, busy}, 32'h0);
        chk("rstmid_protocol_error", {31'b0, protocol_error}, 32'h0);
        chk("rstmid_misaligned", {31'b0, misaligned}, 32'h0);
      end
      @(posedge clock); #1;
    end
    exp_mis  = 1'b0;
    exp_perr = 1'b0;
    txn(32'h20, 32'h0, 4'h0, 1'b0, 0, -1);
    idle(1);

    // Random traffic, mixing back-to-back and idle gaps.
    for (int t = 0; t < 200; t++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 0) a[31:12] = '0;
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      txn(a, $urandom, s, 1'($urandom), $urandom_range(0, 7), -1);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
    end
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/picorv32_mem_responder.md
Name: picorv32_mem_responder

Overview:
- Synthesizable memory responder for the PicoRV32 native memory interface: it drives mem_ready and mem_rdata and accepts mem_valid, mem_instr, mem_addr, mem_wdata and mem_wstrb from the core.
- Used in formal and simulation harnesses in place of a free solver-driven memory, giving a consistent backing store with bounded, solver-selectable wait states.
- Also checks that the core side obeys the handshake rules and flags violations.

Parameters:
- DEPTH_WORDS, 256: backing store depth in 32-bit words; power of two.
- MAX_WAIT, 4: maximum wait states per transaction.
- WAIT_BITS, 3: width of wait_cycles; must satisfy 2**WAIT_BITS > MAX_WAIT.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  request valid from core.
- mem_instr  in  1  instruction fetch flag.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write enables; 0 means read.
- mem_ready  out  1  transaction complete; one-cycle pulse.
- mem_rdata  out  32  read data; valid only while mem_ready=1.
- wait_cycles  in  WAIT_BITS  requested wait states; free input, solver/bench driven.
- busy  out  1  transaction accepted and not yet completed.
- protocol_error  out  1  sticky core-side handshake violation.
- misaligned  out  1  sticky; a request was accepted with mem_addr[1:0]!=0.

Behaviour:
- Reset: synchronous, active-high.
  - Reset values: mem_ready=0, mem_rdata=0, busy=0, protocol_error=0, misaligned=0, state=IDLE.
  - Backing store is not cleared by reset; it is zero-initialised at time 0 only.
- State machine: IDLE -> WAIT -> RESP -> IDLE.
  - IDLE: if mem_valid=1 in cycle T, accept the request.
    - Capture addr, wdata, wstrb and instr.
    - Load cnt = min(wait_cycles, MAX_WAIT).
    - Go to WAIT; busy=1 from T+1.
  - WAIT: if cnt==0, go to RESP; else decrement cnt.
  - RESP: mem_ready=1 for exactly this one cycle; next state IDLE.
- Latency: for a request accepted at cycle T with W = min(wait_cycles@T, MAX_WAIT), mem_ready is high in cycle T+2+W only. Minimum latency is 2 cycles.
- Clamping: wait_cycles > MAX_WAIT is treated as MAX_WAIT. This is not an error.
- Addressing: word index = captured addr[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Alignment: addr[1:0] is ignored for the access itself; a nonzero value sets misaligned.
- Reads (wstrb==0):
  - mem_rdata equals the stored word during the RESP cycle.
  - mem_rdata=0 in all other cycles.
- Writes (wstrb!=0):
  - Byte lane i is updated with wdata[8i+7:8i] if wstrb[i], at the rising edge that ends the RESP cycle.
  - mem_rdata returns the pre-write word during RESP.
- Back-to-back: the cycle after RESP is IDLE. If mem_valid=1 there, a new request is accepted immediately. No request is accepted in WAIT or RESP.
- Protocol check, applied from the cycle after acceptance through RESP. protocol_error sets, and stays set, if any of these occur:
  - mem_valid=0;
  - mem_addr, mem_wdata, mem_wstrb or mem_instr differs from the captured value.
- After a violation, the transaction still completes using the captured values.
- Reset mid-transaction:
  - The transaction is abandoned and no write is performed.
  - mem_ready stays 0; state returns to IDLE in the cycle after reset.
- mem_instr has no effect on data; it participates only in the protocol check.

Decomposition:
- Package picorv32_mem_pkg:
  - state enum {IDLE, WAIT, RESP};
  - a clamp helper function;
  - a localparam for index width, derived from DEPTH_WORDS.
- Sub-module picorv32_mem_ram:
  - DEPTH_WORDS x 32 storage;
  - one combinational read port;
  - one byte-masked synchronous write port;
  - zero-initialised at time 0.

Test Plan:
- Word write then read, zero wait:
  - Stimulus: write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, wait 0 at T.
  - Required: mem_ready high only at T+2.
  - Then read 0x10: mem_rdata=0xDEADBEEF in its ready cycle; misaligned and protocol_error stay 0.
- Byte-lane merge:
  - Stimulus: write 0x11223344 with wstrb 0xF, then 0x000000AA with wstrb 0x1.
  - Required: read returns 0x112233AA.
- Clamped wait:
  - Stimulus: wait_cycles=7 with MAX_WAIT=4, request at T.
  - Required: mem_ready at T+6 only; busy high T+1..T+6.
- Address wrap and misalignment:
  - Stimulus: write 0x55 to 0x00000400 with DEPTH_WORDS=256, then read 0x00000000.
  - Required: read returns 0x00000055.
  - Stimulus: request at 0x00000002.
  - Required: misaligned=1 and stays 1 until reset.
- Protocol violation:
  - Stimulus: drop mem_valid at T+1 during a wait-3 read.
  - Required: protocol_error=1 from T+2, sticky; mem_ready still pulses at T+5.
- Reset mid-transaction:
  - Stimulus: write 0xFFFFFFFF to 0x20 with wait 3; assert reset at T+2.
  - Required: no mem_ready pulse; a later read of 0x20 returns the prior value (0).
